perst_seq_ctrl: RTL and testbench



---
 rtl/perst_seq_ctrl.sv | 133 +++++++++++++
 tb/tb_perst_seq_ctrl.sv | 133 +++++++++++++
 2 files changed

// File: rtl/perst_seq_ctrl.sv
// PERST# sequencer for the CPU0, CPU1 and PCH PCIe reset domains.
// Each domain enforces a minimum assertion hold plus its own staggered release delay.

module perst_seq_dom #(
  parameter int CNT_W      = 16,
  parameter int MIN_ASSERT = 100,
  parameter int DLY        = 10
) (
  input  logic iClk,
  input  logic iRst,
  input  logic src,
  input  logic force_assert,
  output logic rel_nxt,
  output logic perst_n
);
  typedef enum logic [1:0] {ST_ASSERT, ST_WAIT, ST_REL} state_t;

  localparam logic [CNT_W-1:0] MIN_C  = CNT_W'(MIN_ASSERT);
  localparam logic [CNT_W-1:0] DLY_M1 = CNT_W'(DLY - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q <= ST_ASSERT;
      cnt_q   <= '0;
      perst_n <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      perst_n <= (state_d == ST_REL);
    end
  end

  // Loss of source or a force request always wins over a pending release.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_ASSERT: begin
        if (cnt_q != MIN_C) cnt_d = cnt_q + 1'b1;
        if (src && (cnt_q == MIN_C) && !force_assert) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (!src || force_assert) begin
          state_d = ST_ASSERT;
          cnt_d   = '0;
        end else if (cnt_q == DLY_M1) begin
          state_d = ST_REL;
          cnt_d   = '0;
        end
      end
      ST_REL: begin
        cnt_d = '0;
        if (!src || force_assert) state_d = ST_ASSERT;
      end
      default: begin
        state_d = ST_ASSERT;
        cnt_d   = '0;
      end
    endcase
  end

  assign rel_nxt = (state_d == ST_REL);
endmodule

module perst_seq_ctrl #(
  parameter int CNT_W      = 16,
  parameter int MIN_ASSERT = 100,
  parameter int DLY_CPU0   = 10,
  parameter int DLY_CPU1   = 20,
  parameter int DLY_PCH    = 30
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       PWRG_CPUPWRGD_LVC1,
  input  logic       RST_PLTRST_N,
  input  logic [2:0] FM_RST_PERST_BIT,
  input  logic       iForceAssert,
  output logic       RST_PCIE_CPU0_DEV_PERST_N,
  output logic       RST_PCIE_CPU1_DEV_PERST_N,
  output logic       RST_PCIE_PCH_DEV_PERST_N,
  output logic       oPerstAllRel
);
  localparam int NUM_DOM = 3;

  // Straps, platform reset and power-good share one 2-flop synchronizer bank.
  logic [4:0]         meta_q, sync_q;
  logic [NUM_DOM-1:0] strap_s, src, rel_nxt, perst_n;
  logic               pltrst_s, pwrgd_s;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= {FM_RST_PERST_BIT, RST_PLTRST_N, PWRG_CPUPWRGD_LVC1};
      sync_q <= meta_q;
    end
  end

  assign {strap_s, pltrst_s, pwrgd_s} = sync_q;
  assign src = (strap_s & {NUM_DOM{pltrst_s}}) | (~strap_s & {NUM_DOM{pwrgd_s}});

  for (genvar g = 0; g < NUM_DOM; g++) begin : g_dom
    perst_seq_dom #(
      .CNT_W      (CNT_W),
      .MIN_ASSERT (MIN_ASSERT),
      .DLY        ((g == 0) ? DLY_CPU0 : (g == 1) ? DLY_CPU1 : DLY_PCH)
    ) u_dom (
      .iClk         (iClk),
      .iRst         (iRst),
      .src          (src[g]),
      .force_assert (iForceAssert),
      .rel_nxt      (rel_nxt[g]),
      .perst_n      (perst_n[g])
    );
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) oPerstAllRel <= 1'b0;
    else      oPerstAllRel <= &rel_nxt;
  end

  assign RST_PCIE_CPU0_DEV_PERST_N = perst_n[0];
  assign RST_PCIE_CPU1_DEV_PERST_N = perst_n[1];
  assign RST_PCIE_PCH_DEV_PERST_N  = perst_n[2];
endmodule

// File: tb/tb_perst_seq_ctrl.sv
// Directed bench for perst_seq_ctrl with MIN_ASSERT=4, delays 2/5/8.
// Expected edges are hand-computed tick offsets from each stimulus change.

module tb_perst_seq_ctrl;
  localparam int NV = 9999;

  logic       iClk = 1'b0;
  logic       iRst = 1'b1;
  logic       pwrgd = 1'b0;
  logic       pltrst = 1'b0;
  logic [2:0] straps = 3'b000;
  logic       force_a = 1'b0;
  logic       cpu0, cpu1, pch, all_rel;

  int n_vec = 0;
  int n_err = 0;
  int k = 0;

  perst_seq_ctrl #(
    .CNT_W(16), .MIN_ASSERT(4), .DLY_CPU0(2), .DLY_CPU1(5), .DLY_PCH(8)
  ) dut (
    .iClk                      (iClk),
    .iRst                      (iRst),
    .PWRG_CPUPWRGD_LVC1        (pwrgd),
    .RST_PLTRST_N              (pltrst),
    .FM_RST_PERST_BIT          (straps),
    .iForceAssert              (force_a),
    .RST_PCIE_CPU0_DEV_PERST_N (cpu0),
    .RST_PCIE_CPU1_DEV_PERST_N (cpu1),
    .RST_PCIE_PCH_DEV_PERST_N  (pch),
    .oPerstAllRel              (all_rel)
  );

  always #5 iClk = ~iClk;

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got {all,pch,cpu1,cpu0}=%b expected %b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  // Each domain is expected high for r <= k < f, counting ticks since k was cleared.
  task automatic watch(input int n, input int r0, input int f0, input int r1,
                       input int f1, input int r2, input int f2, input string tag);
    logic [3:0] e;
    for (int i = 0; i < n; i++) begin
      tick();
      k++;
      e[0] = (k >= r0) && (k < f0);
      e[1] = (k >= r1) && (k < f1);
      e[2] = (k >= r2) && (k < f2);
      e[3] = &e[2:0];
      chk($sformatf("%s k=%0d", tag, k), {all_rel, pch, cpu1, cpu0}, e);
    end
  endtask

  task automatic pulse_reset();
    tick();
    iRst = 1'b1;
    tick();
    iRst = 1'b0;
  endtask

  initial begin
    // 1: reset with pins toggling, then sources low
    for (int i = 0; i < 6; i++) begin
      tick();
      pltrst = ~pltrst;
      pwrgd  = (i % 3) == 0;
      straps = 3'(i);
      chk($sformatf("rst_hold %0d", i), {all_rel, pch, cpu1, cpu0}, 4'b0000);
    end
    pltrst = 1'b0; pwrgd = 1'b0; straps = 3'b111;
    iRst = 1'b0;
    k = 0; watch(12, NV, NV, NV, NV, NV, NV, "pwrup_low");

    // 2: staggered release from PLTRST
    k = 0; pltrst = 1'b1;
    watch(12, 5, NV, 8, NV, 11, NV, "stagger");

    // 3: mixed sources
    pulse_reset();
    straps = 3'b010; pltrst = 1'b0; pwrgd = 1'b0;
    k = 0; watch(10, NV, NV, NV, NV, NV, NV, "mix_idle");
    k = 0; pwrgd = 1'b1;
    watch(20, 5, NV, NV, NV, 11, NV, "mix_pwrgd");
    k = 0; pltrst = 1'b1;
    watch(10, 0, NV, 8, NV, 0, NV, "mix_pltrst");

    // 4: 3-cycle PLTRST glitch while CPU1/PCH are in WAIT
    pulse_reset();
    straps = 3'b111; pltrst = 1'b0; pwrgd = 1'b0;
    k = 0; watch(10, NV, NV, NV, NV, NV, NV, "glitch_idle");
    k = 0; pltrst = 1'b1;
    watch(3, 5, 6, 16, NV, 19, NV, "glitch_pre");
    pltrst = 1'b0;
    watch(3, 5, 6, 16, NV, 19, NV, "glitch_low");
    pltrst = 1'b1;
    watch(14, 13, NV, 16, NV, 19, NV, "glitch_post");

    // 5a: PCH strap moves to low PWRGD
    k = 0; straps = 3'b011;
    watch(6, 0, NV, 0, NV, 0, 3, "strap_flip");

    // 5b: one-cycle force
    k = 0; force_a = 1'b1;
    watch(1, NV, NV, NV, NV, NV, NV, "force_fall");
    force_a = 1'b0;
    watch(13, 8, NV, 11, NV, NV, NV, "force_rerel");

    // 6: async reset with CPU0 in REL and CPU1 in WAIT
    k = 0; force_a = 1'b1;
    watch(1, NV, NV, NV, NV, NV, NV, "pre6_force");
    force_a = 1'b0;
    watch(8, 8, NV, NV, NV, NV, NV, "pre6_rel");
    #3 iRst = 1'b1;
    #1 chk("async_rst", {all_rel, pch, cpu1, cpu0}, 4'b0000);
    @(negedge iClk);
    chk("async_rst_hold", {all_rel, pch, cpu1, cpu0}, 4'b0000);
    iRst = 1'b0;
    k = 0; watch(12, 7, NV, 10, NV, NV, NV, "post_rst_hold");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
